// File: rtl/microwave_control.sv
// Microwave cooking-time controller: keypad digit capture, BCD countdown on the
// encoder tick, magnetron gating from start/stop/door, and completion flag.
module microwave_control #(
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       pgt,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_open,
   output logic       enbn,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       mag_on,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_SEC - 1);

   state_e     state_q, state_d;
   logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
   logic [7:0] tick_q, tick_d;
   logic [1:0] blank_q, blank_d;
   logic       startn_q, stopn_q;
   logic       pgt_s1_q, pgt_s2_q, pgt_s3_q;
   logic       enbn_q, enbn_d, mag_q, mag_d, done_q, done_d;

   logic        start_ev_s, stop_ev_s, pgt_ev_s, time_zero_s;
   logic [11:0] dec_s;

   // Time-down step; tens above 5 are left as entered and simply count down.
   function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] t,
                                           input logic [3:0] o);
      logic [11:0] r;
      if (o != 4'd0) begin
         r = {m, t, o - 4'd1};
      end else if (t != 4'd0) begin
         r = {m, t - 4'd1, 4'd9};
      end else begin
         r = {m - 4'd1, 4'd5, 4'd9};
      end
      return r;
   endfunction

   assign start_ev_s  = startn_q & ~startn;
   assign stop_ev_s   = stopn_q & ~stopn;
   // A pgt edge landing while the encoder is switching source is spurious.
   assign pgt_ev_s    = pgt_s2_q & ~pgt_s3_q & (blank_q == 2'd0);
   assign time_zero_s = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
   assign dec_s       = bcd_dec(min_q, tens_q, ones_q);

   // Next-state, digit, tick and output-decode logic.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      tick_d  = tick_q;
      case (state_q)
         S_IDLE, S_ENTRY: begin
            if (stop_ev_s) begin
               {min_d, tens_d, ones_d} = 12'd0;
               state_d = S_IDLE;
            end else if (start_ev_s && !door_open && !time_zero_s) begin
               state_d = S_COOK;
               tick_d  = 8'd0;
            end else if (pgt_ev_s && (D <= 4'd9)) begin
               min_d   = tens_q;
               tens_d  = ones_q;
               ones_d  = D;
               state_d = S_ENTRY;
            end else begin
               state_d = state_q;
            end
         end
         S_COOK: begin
            if (stop_ev_s || door_open) begin
               state_d = S_PAUSE;
            end else if (pgt_ev_s) begin
               if (tick_q >= TICK_LAST) begin
                  tick_d = 8'd0;
                  {min_d, tens_d, ones_d} = dec_s;
                  if (dec_s == 12'd0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_COOK;
                  end
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_PAUSE: begin
            if (stop_ev_s) begin
               {min_d, tens_d, ones_d} = 12'd0;
               state_d = S_IDLE;
            end else if (start_ev_s && !door_open) begin
               state_d = S_COOK;
               tick_d  = 8'd0;
            end else begin
               state_d = state_q;
            end
         end
         S_DONE: begin
            if (stop_ev_s || start_ev_s) begin
               {min_d, tens_d, ones_d} = 12'd0;
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            {min_d, tens_d, ones_d} = 12'd0;
            tick_d  = 8'd0;
            state_d = S_IDLE;
         end
      endcase

      enbn_d = (state_d == S_COOK) || (state_d == S_PAUSE) || (state_d == S_DONE);
      mag_d  = (state_d == S_COOK);
      done_d = (state_d == S_DONE);
      if (enbn_d != enbn_q) begin
         blank_d = 2'd2;
      end else if (blank_q != 2'd0) begin
         blank_d = blank_q - 2'd1;
      end else begin
         blank_d = 2'd0;
      end
   end

   // State, digits, synchronizers, button history and registered outputs.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state_q  <= S_IDLE;
         min_q    <= 4'd0;
         tens_q   <= 4'd0;
         ones_q   <= 4'd0;
         tick_q   <= 8'd0;
         blank_q  <= 2'd0;
         startn_q <= 1'b1;
         stopn_q  <= 1'b1;
         pgt_s1_q <= 1'b0;
         pgt_s2_q <= 1'b0;
         pgt_s3_q <= 1'b0;
         enbn_q   <= 1'b0;
         mag_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         min_q    <= min_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         tick_q   <= tick_d;
         blank_q  <= blank_d;
         startn_q <= startn;
         stopn_q  <= stopn;
         pgt_s1_q <= pgt;
         pgt_s2_q <= pgt_s1_q;
         pgt_s3_q <= pgt_s2_q;
         enbn_q   <= enbn_d;
         mag_q    <= mag_d;
         done_q   <= done_d;
      end
   end

   assign enbn     = enbn_q;
   assign mag_on   = mag_q;
   assign done     = done_q;
   assign min_ones = min_q;
   assign sec_tens = tens_q;
   assign sec_ones = ones_q;

endmodule
